// File: rtl/seg_pkg.sv
// Purpose : shared constants for the 4-digit hex scanner (segment codes, idle patterns).
// Latency : n/a (constants and a pure helper function only).
// Backpressure: n/a.
//
// Segment words are active-low, bit 6 = a ... bit 0 = g.
// Anode words are active-low, bit i drives digit i.
package seg_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Index n holds the glyph for hex value n.
    localparam logic [6:0] SEG_CODE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // True when digit idx is a leading zero: it is not the rightmost digit
    // and it and every digit to its left are zero.
    function automatic logic is_leading_zero(input logic [15:0] word, input digit_idx_t idx);
        logic r;
        r = 1'b0;
        case (idx)
            2'd1:    r = (word[15:4]  == 12'h000);
            2'd2:    r = (word[15:8]  == 8'h00);
            2'd3:    r = (word[15:12] == 4'h0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Purpose : hex nibble to active-low 7-segment glyph.
// Latency : purely combinational.
// Backpressure: none.
//
// Ports: nib_i [3:0] hex value in; seg_o [6:0] active-low segments out (a..g).
module seg7_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_CODE[nib_i];

endmodule

// File: rtl/seg_scan.sv
// Purpose : time-multiplexed driver for a 4-digit 7-segment display with a one-word input buffer.
// Latency : seg/an registered, 1 cycle behind the scan index; a word shows from the frame end after it is accepted.
// Backpressure: in_ready drops while a word waits for frame end; it rises again in the cycle after the hand-over.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   in_data/valid/ready  16-bit word (digit 0 = [3:0]) with valid/ready handshake
//   en, blank_lz      display enable, leading-zero blanking
//   seg, an           active-low segments (a..g) and anodes
//   frame_tick        high in the cycle whose closing edge wraps the digit index 3->0
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        en,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned     PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   pend_q, pend_d;
    logic          full_q, full_d;
    logic [15:0]   disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          slot_tick;
    logic          frame_end;
    logic          accept;
    logic [3:0]    cur_nib;
    logic [6:0]    dec_seg;

    // Scan timing only advances while enabled, so disabling freezes the
    // position and re-enabling continues the same slot.
    assign slot_tick = en && (presc_q == PRESC_LAST);
    assign frame_end = slot_tick && (idx_q == 2'd3);
    assign accept    = in_valid && !full_q;

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (en) begin
            presc_d = slot_tick ? '0 : presc_q + PW'(1);
        end
        if (slot_tick) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // The display word is swapped only at frame end so a frame never mixes
    // digits of two words. in_ready is low whenever full is set, so a
    // hand-over and a new accept can never coincide; a word offered in the
    // hand-over cycle is therefore taken on the following edge and waits a
    // whole frame.
    always_comb begin
        pend_d = pend_q;
        full_d = full_q;
        disp_d = disp_q;
        if (frame_end && full_q) begin
            disp_d = pend_q;
            full_d = 1'b0;
        end else if (accept) begin
            pend_d = in_data;
            full_d = 1'b1;
        end
    end

    assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];

    seg7_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        if (en) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = (blank_lz && is_leading_zero(disp_q, idx_q)) ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            pend_q  <= 16'h0000;
            full_q  <= 1'b0;
            disp_q  <= 16'h0000;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign in_ready   = !full_q;
    assign frame_tick = frame_end;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule

// File: tb/tb_seg_scan.sv
// Purpose : randomized + directed bench for seg_scan with a cycle scoreboard.
// Latency : n/a.
// Backpressure: n/a.
module tb_seg_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        en;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    seg_scan #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .en         (en),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rdy;
        logic       tick;
        logic [6:0] seg;
        logic [3:0] an;
    } exp_t;

    exp_t scb[$];
    exp_t mx;

    int checks   = 0;
    int failures = 0;

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: position within the frame as a count of enabled cycles,
    // the pending word as a one-deep buffer, and the word on display.
    int          m_ecnt;
    logic        m_full;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;

    function automatic void chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] w, input int i, input logic b);
        logic [15:0] upper;
        logic [15:0] nib;
        upper = w >> (4 * i);
        nib   = upper & 16'h000F;
        if (b && i > 0 && upper == 16'h0000) return 7'b1111111;
        return hex_tab[nib[3:0]];
    endfunction

    function automatic void model_reset();
        m_ecnt = 0;
        m_full = 1'b0;
        m_pend = 16'h0000;
        m_disp = 16'h0000;
        m_seg  = 7'b1111111;
        m_an   = 4'b1111;
    endfunction

    // Monitor: every cycle with an outstanding expectation is compared at the
    // falling edge.
    always @(negedge clk) begin
        if (!rst && scb.size() > 0) begin
            mx = scb.pop_front();
            chk("in_ready",   {6'b0, in_ready},   {6'b0, mx.rdy});
            chk("frame_tick", {6'b0, frame_tick}, {6'b0, mx.tick});
            chk("seg",        seg,                mx.seg);
            chk("an",         {3'b0, an},         {3'b0, mx.an});
        end
    end

    // One clock: drive inputs just after the edge, queue what this cycle must
    // show, then advance the model across the next edge.
    task automatic step(input logic v, input logic [15:0] d, input logic e, input logic b,
                        output logic acc, output logic tk);
        exp_t x;
        int   idx;
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        en       = e;
        blank_lz = b;
        x.rdy  = !m_full;
        x.tick = e && (m_ecnt == FRAME - 1);
        x.seg  = m_seg;
        x.an   = m_an;
        scb.push_back(x);
        idx = m_ecnt / DIV;
        if (e) begin
            m_an  = 4'b1111 ^ (4'(1) << idx);
            m_seg = model_seg(m_disp, idx, b);
        end else begin
            m_an  = 4'b1111;
            m_seg = 7'b1111111;
        end
        acc = 1'b0;
        if (x.tick && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end else if (v && !m_full) begin
            m_pend = d;
            m_full = 1'b1;
            acc    = 1'b1;
        end
        if (e) m_ecnt = (m_ecnt + 1) % FRAME;
        tk = x.tick;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        en       = 1'b0;
        blank_lz = 1'b0;
        in_data  = 16'h0000;
        rst      = 1'b1;
        #1;
        chk("rst_an",         {3'b0, an},         7'b0001111);
        chk("rst_seg",        seg,                7'b1111111);
        chk("rst_in_ready",   {6'b0, in_ready},   7'b0000001);
        chk("rst_frame_tick", {6'b0, frame_tick}, 7'b0000000);
        scb.delete();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic b);
        logic acc, tk;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 4 * FRAME) begin
            step(1'b1, d, 1'b1, b, acc, tk);
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout word=%h not accepted", d);
        end
    endtask

    task automatic idle(input int n, input logic b);
        logic acc, tk;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b1, b, acc, tk);
    endtask

    logic [3:0] an_seq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_seq [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};

    initial begin
        logic        acc, tk;
        int          n;
        logic [15:0] mask;
        rst      = 1'b0;
        in_valid = 1'b0;
        en       = 1'b0;
        blank_lz = 1'b0;
        in_data  = 16'h0000;
        model_reset();
        #2;
        do_reset();

        // 12AF: wait for the frame end that hands it over, then check the
        // first displayed frame digit by digit against literal codes.
        send(16'h12AF, 1'b0);
        tk = 1'b0;
        n  = 0;
        while (!tk && n < 2 * FRAME) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, acc, tk);
            n++;
        end
        if (!tk) begin
            checks++;
            failures++;
            $display("FAIL frame_end_timeout no frame end seen");
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc, tk);
        for (int j = 0; j < FRAME; j++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, acc, tk);
            chk("scan_an",  {3'b0, an}, {3'b0, an_seq[j / DIV]});
            chk("scan_seg", seg,        seg_seq[j / DIV]);
        end

        // Back-to-back words: the second waits for the hand-over.
        send(16'h3456, 1'b0);
        send(16'h789C, 1'b0);
        idle(3 * FRAME, 1'b0);

        // Leading-zero blanking.
        send(16'h0005, 1'b1);
        idle(2 * FRAME + 2, 1'b1);
        send(16'h0100, 1'b1);
        idle(2 * FRAME + 2, 1'b1);

        // Disable while digit 2 is partway through its slot, then resume.
        n = 0;
        while (m_ecnt != 2 * DIV + 1 && n < 2 * FRAME) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, acc, tk);
            n++;
        end
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, acc, tk);
        idle(2 * FRAME, 1'b0);

        // Randomized traffic, enable and blanking.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 4))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h00FF;
                2:       mask = 16'h000F;
                3:       mask = 16'h0F0F;
                default: mask = 16'h0000;
            endcase
            step(($urandom_range(0, 2) == 0), 16'($urandom) & mask,
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1), acc, tk);
        end

        // Reset mid-frame with a word pending.
        n = 0;
        while (!m_full && n < 4 * FRAME) begin
            step(1'b1, 16'hBEEF, 1'b1, 1'b0, acc, tk);
            n++;
        end
        chk("pending_before_rst", {6'b0, m_full}, 7'b0000001);
        @(posedge clk);
        #3;
        do_reset();
        idle(3 * FRAME, 1'b0);
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) == 0), 16'($urandom),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1), acc, tk);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot (legal range 2..2^20).
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  16  four hex nibbles; [3:0] = digit 0 (rightmost).
REQ-005 in_valid  input  1  in_data offered this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 en  input  1  display enable; 0 blanks all digits.
REQ-008 blank_lz  input  1  1 = blank leading zero digits.
REQ-009 seg  output  7  segments, active-low, seg[6]=a ... seg[0]=g.
REQ-010 an  output  4  digit anodes, active-low, an[i] drives digit i.
REQ-011 frame_tick  output  1  one-cycle pulse at each frame end.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 while en=1, wrap to 0, and raise an internal slot tick on terminal count.
REQ-013 Digit index (0..3) SHALL increment on slot tick, wrapping 3->0; the 3->0 wrap is frame end.
REQ-014 frame_tick SHALL be high for exactly the cycle in which the 3->0 wrap occurs.
REQ-015 Pending register SHALL hold one 16-bit word plus a full flag; in_ready SHALL equal NOT full.
REQ-016 A transfer SHALL occur when in_valid=1 and in_ready=1 on a rising edge: in_data is captured, full set.
REQ-017 At frame end with full=1, pending SHALL be copied to the display register and full cleared in the same cycle.
REQ-018 A word accepted in the frame-end cycle SHALL NOT display until the next frame end.
REQ-019 Display register SHALL change only at frame end, so no frame shows mixed old/new digits.
REQ-020 seg and an SHALL be registered, reflecting index and display register with 1-cycle latency.
REQ-021 For active digit i, an SHALL have bit i low and others high; seg SHALL be the hex code of nibble i.
REQ-022 Hex codes: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-023 With blank_lz=1, digit i>0 SHALL show seg=1111111 (anode still driven) if nibbles i..3 are all zero; digit 0 SHALL never be blanked.
REQ-024 With en=0, next cycle an=1111 and seg=1111111; prescaler and index SHALL hold; handshake and frame-end transfer are unaffected except no frame end occurs.
REQ-025 Re-enabling SHALL resume from the held index and prescaler value.

Reset
REQ-026 On rst: an=1111, seg=1111111, frame_tick=0, prescaler=0, index=0, display register=0, full=0 (in_ready=1).
REQ-027 Reset asserted mid-frame SHALL discard pending data immediately; first frame after release displays 0000 (or blanked per blank_lz).

Structure
REQ-028 Package seg_pkg SHALL hold the 16 segment codes, SEG_BLANK=7'b1111111 and AN_OFF=4'b1111.
REQ-029 Nibble-to-segment decode SHALL be a combinational sub-module seg7_dec (4-bit in, 7-bit out).

Verification (REFRESH_DIV=4)
REQ-030 Assert rst -> an=1111, seg=1111111, in_ready=1, frame_tick=0 with no clock edge.
REQ-031 Load 16'h12AF, en=1, blank_lz=0 -> after next frame end, an cycles 1110,1101,1011,0111 at 4 clk each; seg 0111000,0001000,0010010,1001111.
REQ-032 Two back-to-back in_valid words -> first accepted, in_ready=0 until frame end, second accepted cycle after; each displays a full frame.
REQ-033 blank_lz=1, in_data=16'h0005 -> digit 0 seg=0100100, digits 1-3 seg=1111111; 16'h0100 -> digit 2 shows 1001111, digit 3 blank, digits 0-1 show 0000001.
REQ-034 en=0 at index 2 -> next cycle an=1111; en=1 after 10 cycles -> digit 2 resumes with remaining prescaler count.
REQ-035 rst mid-frame with full=1 -> outputs blank immediately; after release in_ready=1 and display shows 0.
